// File: rtl/sensor_gen.sv
// Multi-channel synthetic sensor sample generator: HOLD / RAMP / TRI waveforms
// (plus LFSR NOISE when compiled with SENSOR_GEN_NOISE_EN), rate-divided and clamped.
module sensor_gen #(
  parameter int W     = 8,
  parameter int NCH   = 3,
  parameter int PHASE = 32,
  parameter int DIV_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   rate_div,
  input  logic [W-1:0]       step,
  input  logic [W-1:0]       clamp_max,
  output logic [NCH*W-1:0]   data,
  output logic               valid,
  output logic [7:0]         seq
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_RAMP  = 2'b01,
    MODE_TRI   = 2'b10,
    MODE_NOISE = 2'b11
  } mode_e;

  // Per-channel start offset, truncated to the sample width.
  function automatic logic [W-1:0] phase_off(input int k);
    return W'(k * PHASE);
  endfunction

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  mode_e            eff_mode;
  mode_e            last_mode;

  logic [W-1:0]     acc     [NCH];
  logic [W-1:0]     acc_nxt [NCH];
  logic [NCH-1:0]   dir;
  logic [NCH-1:0]   dir_nxt;
  logic [NCH*W-1:0] data_nxt;

`ifdef SENSOR_GEN_NOISE_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_nxt;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
`endif

  assign tick = en && (div_cnt == rate_div);

  always_comb begin
    eff_mode = mode_e'(mode);
`ifndef SENSOR_GEN_NOISE_EN
    if (mode == MODE_NOISE) eff_mode = MODE_HOLD;
`endif
  end

  // NOTE: every signal written here gets a default before any branch; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin : next_state
    logic [W:0]   up_sum;
    logic         dir_k;
    logic [W-1:0] value;
    up_sum   = '0;
    dir_k    = 1'b0;
    value    = '0;
    data_nxt = '0;
    dir_nxt  = dir;
    for (int k = 0; k < NCH; k++) begin
      acc_nxt[k] = acc[k];
      up_sum     = {1'b0, acc[k]} + {1'b0, step};
      // A fresh entry into TRI always starts climbing.
      dir_k      = (last_mode == MODE_TRI) ? dir[k] : 1'b0;
      case (eff_mode)
        MODE_RAMP: acc_nxt[k] = acc[k] + step;
        MODE_TRI: begin
          if (!dir_k) begin
            if (up_sum >= {1'b0, clamp_max}) begin
              acc_nxt[k] = clamp_max;
              dir_nxt[k] = 1'b1;
            end else begin
              acc_nxt[k] = up_sum[W-1:0];
              dir_nxt[k] = 1'b0;
            end
          end else begin
            if (acc[k] < step) begin
              acc_nxt[k] = '0;
              dir_nxt[k] = 1'b0;
            end else begin
              acc_nxt[k] = acc[k] - step;
              dir_nxt[k] = 1'b1;
            end
          end
        end
        default: acc_nxt[k] = acc[k];
      endcase
      value = acc_nxt[k];
`ifdef SENSOR_GEN_NOISE_EN
      if (eff_mode == MODE_NOISE) value = lfsr_nxt[W-1:0] ^ phase_off(k);
`endif
      data_nxt[k*W +: W] = (value > clamp_max) ? clamp_max : value;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: acc/dir are small register banks, not RAM, so they are reset
      // explicitly to their phase offsets.
      for (int k = 0; k < NCH; k++) acc[k] <= phase_off(k);
      dir       <= '0;
      div_cnt   <= '0;
      valid     <= 1'b0;
      seq       <= '0;
      data      <= '0;
      last_mode <= MODE_HOLD;
`ifdef SENSOR_GEN_NOISE_EN
      lfsr      <= 16'hACE1;
`endif
    end else begin
      valid <= tick;
      if (!en || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + 1'b1;
      if (tick) begin
        for (int k = 0; k < NCH; k++) acc[k] <= acc_nxt[k];
        dir       <= dir_nxt;
        data      <= data_nxt;
        seq       <= seq + 8'd1;
        last_mode <= eff_mode;
`ifdef SENSOR_GEN_NOISE_EN
        if (eff_mode == MODE_NOISE) lfsr <= lfsr_nxt;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sensor_gen.sv
// Directed self-checking bench for sensor_gen at default parameters
// (W=8, NCH=3, PHASE=32), with hand-computed expected sample sets.
module tb_sensor_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  rate_div;
  logic [7:0]  step;
  logic [7:0]  clamp_max;
  logic [23:0] data;
  logic        valid;
  logic [7:0]  seq;

  int n_checks = 0;
  int n_fail   = 0;

  sensor_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .mode      (mode),
    .rate_div  (rate_div),
    .step      (step),
    .clamp_max (clamp_max),
    .data      (data),
    .valid     (valid),
    .seq       (seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle away from it.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic check_sample(input string tag, input logic [23:0] exp_data,
                              input logic [7:0] exp_seq);
    check({tag, ".valid"}, valid, 1'b1);
    check({tag, ".data"},  data,  exp_data);
    check({tag, ".seq"},   seq,   exp_seq);
  endtask

  logic [15:0] lfsr_m;
  logic [23:0] exp_noise;

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b01; rate_div = 8'd0; step = 8'd1; clamp_max = 8'd255;

    // Reset state, held across edges, then idle with en low.
    edge_step();
    edge_step();
    check("rst.valid", valid, 1'b0);
    check("rst.seq",   seq,   8'd0);
    check("rst.data",  data,  24'h0);
    rst = 1'b1;
    edge_step();
    check("idle.data",  data,  24'h0);
    check("idle.valid", valid, 1'b0);

    // RAMP, rate_div=0, step=1: first tick 1/33/65, then +1 every cycle.
    en = 1'b1;
    edge_step();
    check_sample("ramp1", 24'h412101, 8'd1);
    edge_step();
    check_sample("ramp2", 24'h422202, 8'd2);
    edge_step();
    check_sample("ramp3", 24'h432303, 8'd3);

    // rate_div=3: one valid in every 4 edges.
    en = 1'b0;
    edge_step();
    check("en_off.valid", valid, 1'b0);
    check("en_off.seq",   seq,   8'd3);
    rate_div = 8'd3;
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edge_step();
      check("div4.gap", valid, 1'b0);
    end
    edge_step();
    check_sample("div4.tick", 24'h442404, 8'd4);
    edge_step();
    edge_step();
    check("div4.mid", valid, 1'b0);
    // Drop en mid-period for 2 cycles: partial period discarded.
    en = 1'b0;
    edge_step();
    check("pause1.valid", valid, 1'b0);
    edge_step();
    check("pause2.valid", valid, 1'b0);
    check("pause.seq",    seq,   8'd4);
    check("pause.data",   data,  24'h442404);
    en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edge_step();
      check("resume.gap", valid, 1'b0);
    end
    edge_step();
    check_sample("resume.tick", 24'h452505, 8'd5);

    // RAMP wrap and clamp.
    en = 1'b0; rate_div = 8'd0; step = 8'd240; clamp_max = 8'd255;
    apply_reset();
    en = 1'b1;
    edge_step();
    check_sample("wrap.a", 24'h3010F0, 8'd1);
    step = 8'd16;
    edge_step();
    check_sample("wrap.b", 24'h402000, 8'd2);
    step = 8'd200; clamp_max = 8'd100;
    edge_step();
    check_sample("clamp100", 24'h086464, 8'd3);
    step = 8'd0; clamp_max = 8'd0;
    edge_step();
    check_sample("clamp0", 24'h000000, 8'd4);
    clamp_max = 8'd255;
    edge_step();
    check_sample("step0", 24'h08E8C8, 8'd5);

    // TRI, step=40, clamp=100 from reset offsets 0/32/64.
    en = 1'b0; mode = 2'b10; step = 8'd40; clamp_max = 8'd100;
    apply_reset();
    en = 1'b1;
    edge_step(); check_sample("tri1", 24'h644828, 8'd1);
    edge_step(); check_sample("tri2", 24'h3C6450, 8'd2);
    edge_step(); check_sample("tri3", 24'h143C64, 8'd3);
    edge_step(); check_sample("tri4", 24'h00143C, 8'd4);
    edge_step(); check_sample("tri5", 24'h280014, 8'd5);
    edge_step(); check_sample("tri6", 24'h502800, 8'd6);
    edge_step(); check_sample("tri7", 24'h645028, 8'd7);
    // Leave TRI for one tick, re-enter: ch2 at 100 must climb (clamp), not fall.
    mode = 2'b00;
    edge_step(); check_sample("hold", 24'h645028, 8'd8);
    mode = 2'b10;
    edge_step(); check_sample("tri_reentry", 24'h646450, 8'd9);

    // Mode 11: LFSR noise when compiled in, otherwise identical to HOLD.
    clamp_max = 8'd255;
    mode = 2'b11;
    lfsr_m = 16'hACE1;
    for (int i = 0; i < 4; i++) begin
      edge_step();
`ifdef SENSOR_GEN_NOISE_EN
      lfsr_m = {1'b0, lfsr_m[15:1]} ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
      exp_noise = {lfsr_m[7:0] ^ 8'd64, lfsr_m[7:0] ^ 8'd32, lfsr_m[7:0]};
`else
      exp_noise = 24'h646450;
`endif
      check_sample("mode11", exp_noise, 8'(10 + i));
    end

    // Reset mid-RAMP right after a tick: outputs clear at once.
    mode = 2'b01; step = 8'd1; rate_div = 8'd0;
    edge_step();
    check("pre_rst.valid", valid, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst.valid", valid, 1'b0);
    check("async_rst.seq",   seq,   8'd0);
    check("async_rst.data",  data,  24'h0);
    edge_step();
    check("in_rst.valid", valid, 1'b0);
    rst = 1'b1;
    edge_step();
    check_sample("restart1", 24'h412101, 8'd1);
    edge_step();
    check_sample("restart2", 24'h422202, 8'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
